// File: rtl/conv_feeder_pkg.sv
// Shared state type and buffer sizing for conv_2d_feeder.
package conv_feeder_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_KFETCH,
      ST_KSEND,
      ST_ISWITCH,
      ST_ISEND,
      ST_FINISH
   } feeder_state_t;

   localparam int unsigned KSIZE_DEF = 5;
   localparam int unsigned IMG_W_DEF = 28;
   localparam int unsigned IMG_H_DEF = 28;

   localparam int unsigned KWORDS = KSIZE_DEF * KSIZE_DEF;
   localparam int unsigned IWORDS = IMG_W_DEF * IMG_H_DEF;

   function automatic int unsigned addr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   localparam int unsigned KADDR_W = addr_w(KWORDS);
   localparam int unsigned IADDR_W = addr_w(IWORDS);

endpackage

// File: rtl/feeder_ram.sv
// Simple dual-port buffer: host write port, registered read port that
// returns zero on cycles without a read.
module feeder_ram #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 25,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en && (32'(wr_addr) < DEPTH)) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
      else            rd_data <= '0;
   end

endmodule

// File: rtl/conv_2d_feeder.sv
// Kernel-then-image stream source for conv_2d, played from two host-loaded buffers.
// FEEDER_ROW_GAP_EN: insert one invalid cycle after every image row.
module conv_2d_feeder
   import conv_feeder_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned KSIZE  = KSIZE_DEF,
   parameter int unsigned IMG_W  = IMG_W_DEF,
   parameter int unsigned IMG_H  = IMG_H_DEF
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                wr_en,
   input  logic                                wr_sel,
   input  logic [addr_w(IMG_W*IMG_H)-1:0]      wr_addr,
   input  logic [DATA_W-1:0]                   wr_data,
   input  logic                                start,
   input  logic                                stall,
   output logic                                busy,
   output logic                                done,
   output logic [DATA_W-1:0]                   kernal_input,
   output logic                                kernal_input_valid,
   output logic                                kernal_complete,
   output logic [DATA_W-1:0]                   image_input_pixel,
   output logic                                image_input_valid,
   output logic                                image_complete
);

   localparam int unsigned N_K  = KSIZE * KSIZE;
   localparam int unsigned N_I  = IMG_W * IMG_H;
   localparam int unsigned KA_W = addr_w(N_K);
   localparam int unsigned IA_W = addr_w(N_I);
   localparam logic [KA_W-1:0] K_LAST = KA_W'(N_K - 1);
   localparam logic [IA_W-1:0] I_LAST = IA_W'(N_I - 1);

   feeder_state_t   state, state_d;
   logic [KA_W-1:0] kaddr, kaddr_d;
   logic [IA_W-1:0] iaddr, iaddr_d;
   logic            k_rd, i_rd, busy_d, done_d, kcomp_d, icomp_d;
   logic            host_ok, k_we, i_we;

`ifdef FEEDER_ROW_GAP_EN
   localparam int unsigned CA_W = addr_w(IMG_W);
   localparam logic [CA_W-1:0] C_LAST = CA_W'(IMG_W - 1);
   logic [CA_W-1:0] col, col_d;
   logic            gap, gap_d;
`endif

   assign host_ok = wr_en && (state == ST_IDLE);
   assign k_we    = host_ok && !wr_sel && (32'(wr_addr) < N_K);
   assign i_we    = host_ok &&  wr_sel && (32'(wr_addr) < N_I);

   feeder_ram #(.DATA_W(DATA_W), .DEPTH(N_K), .ADDR_W(KA_W)) u_kram (
      .clk(clk), .rst_n(rst_n),
      .wr_en(k_we), .wr_addr(wr_addr[KA_W-1:0]), .wr_data(wr_data),
      .rd_en(k_rd), .rd_addr(kaddr), .rd_data(kernal_input)
   );

   feeder_ram #(.DATA_W(DATA_W), .DEPTH(N_I), .ADDR_W(IA_W)) u_iram (
      .clk(clk), .rst_n(rst_n),
      .wr_en(i_we), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(i_rd), .rd_addr(iaddr), .rd_data(image_input_pixel)
   );

   always_comb begin
      state_d = state;
      kaddr_d = kaddr;
      iaddr_d = iaddr;
      k_rd    = 1'b0;
      i_rd    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      kcomp_d = kernal_complete;
      icomp_d = image_complete;
`ifdef FEEDER_ROW_GAP_EN
      col_d   = col;
      gap_d   = gap;
`endif
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_KFETCH;
               kaddr_d = '0;
               iaddr_d = '0;
               kcomp_d = 1'b0;
               icomp_d = 1'b0;
`ifdef FEEDER_ROW_GAP_EN
               col_d   = '0;
               gap_d   = 1'b0;
`endif
            end
         end
         ST_KFETCH: begin
            busy_d = 1'b1;
            if (!stall) state_d = ST_KSEND;
         end
         ST_KSEND: begin
            busy_d = 1'b1;
            if (!stall) begin
               k_rd = 1'b1;
               if (kaddr == K_LAST) state_d = ST_ISWITCH;
               else                 kaddr_d = kaddr + 1'b1;
            end
         end
         ST_ISWITCH: begin
            busy_d = 1'b1;
            if (!stall) begin
               kcomp_d = 1'b1;
               state_d = ST_ISEND;
            end
         end
         ST_ISEND: begin
            busy_d = 1'b1;
            if (!stall) begin
`ifdef FEEDER_ROW_GAP_EN
               // address saturates on the last pixel, so the gap that sees I_LAST is the final one
               if (gap) begin
                  gap_d = 1'b0;
                  if (iaddr == I_LAST) state_d = ST_FINISH;
               end else begin
                  i_rd = 1'b1;
                  if (iaddr != I_LAST) iaddr_d = iaddr + 1'b1;
                  if (col == C_LAST) begin
                     col_d = '0;
                     gap_d = 1'b1;
                  end else begin
                     col_d = col + 1'b1;
                  end
               end
`else
               i_rd = 1'b1;
               if (iaddr == I_LAST) state_d = ST_FINISH;
               else                 iaddr_d = iaddr + 1'b1;
`endif
            end
         end
         ST_FINISH: begin
            if (stall) begin
               busy_d = 1'b1;
            end else begin
               done_d  = 1'b1;
               icomp_d = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= ST_IDLE;
         kaddr              <= '0;
         iaddr              <= '0;
         busy               <= 1'b0;
         done               <= 1'b0;
         kernal_input_valid <= 1'b0;
         image_input_valid  <= 1'b0;
         kernal_complete    <= 1'b0;
         image_complete     <= 1'b0;
`ifdef FEEDER_ROW_GAP_EN
         col                <= '0;
         gap                <= 1'b0;
`endif
      end else begin
         state              <= state_d;
         kaddr              <= kaddr_d;
         iaddr              <= iaddr_d;
         busy               <= busy_d;
         done               <= done_d;
         kernal_input_valid <= k_rd;
         image_input_valid  <= i_rd;
         kernal_complete    <= kcomp_d;
         image_complete     <= icomp_d;
`ifdef FEEDER_ROW_GAP_EN
         col                <= col_d;
         gap                <= gap_d;
`endif
      end
   end

endmodule

// File: tb/tb_conv_2d_feeder.sv
// Self-checking bench for conv_2d_feeder: slot-list reference model compared every cycle,
// plus literal timing/data checks from the basic, stall, busy-write, reset and random runs.
module tb_conv_2d_feeder;

   localparam int NK    = 25;
   localparam int NI    = 784;
   localparam int IMG_W = 28;
   localparam int IMG_H = 28;
`ifdef FEEDER_ROW_GAP_EN
   localparam bit GAP_EN   = 1'b1;
   localparam int DONE_REL = 840;
`else
   localparam bit GAP_EN   = 1'b0;
   localparam int DONE_REL = 812;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0;
   logic        wr_sel = 1'b0;
   logic [9:0]  wr_addr = '0;
   logic [15:0] wr_data = '0;
   logic        start = 1'b0;
   logic        stall = 1'b0;
   logic        busy, done, kernal_input_valid, kernal_complete;
   logic        image_input_valid, image_complete;
   logic [15:0] kernal_input, image_input_pixel;

   always #5 clk = ~clk;

   conv_2d_feeder #(.DATA_W(16), .KSIZE(5), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
      .wr_data(wr_data), .start(start), .stall(stall), .busy(busy), .done(done),
      .kernal_input(kernal_input), .kernal_input_valid(kernal_input_valid),
      .kernal_complete(kernal_complete), .image_input_pixel(image_input_pixel),
      .image_input_valid(image_input_valid), .image_complete(image_complete)
   );

   // Reference model: a playback is a list of one-cycle slots; a stalled cycle consumes none.
   typedef enum {S_FETCH, S_KW, S_SWITCH, S_PIX, S_GAP, S_FIN} slot_kind_e;
   typedef struct { slot_kind_e kind; int idx; } slot_t;

   slot_t    slots[$];
   bit [15:0] kmem [NK];
   bit [15:0] imem [NI];
   bit       m_active = 1'b0;
   int       cyc = 0, s_edge = 0, stall_cnt = 0;
   bit       e_busy = 0, e_done = 0, e_kv = 0, e_kc = 0, e_iv = 0, e_ic = 0;
   bit [15:0] e_kd = '0, e_id = '0;

   always @(posedge clk or negedge rst_n) begin
      bit    was_active;
      slot_t s;
      if (!rst_n) begin
         m_active = 0;
         slots.delete();
         {e_busy, e_done, e_kv, e_kc, e_iv, e_ic} = '0;
         e_kd = '0;
         e_id = '0;
      end else begin
         was_active = m_active;
         cyc++;
         {e_done, e_kv, e_iv} = '0;
         e_kd = '0;
         e_id = '0;
         if (was_active) begin
            if (stall) stall_cnt++;
            else begin
               s = slots.pop_front();
               case (s.kind)
                  S_KW:     begin e_kv = 1; e_kd = kmem[s.idx]; end
                  S_SWITCH: e_kc = 1;
                  S_PIX:    begin e_iv = 1; e_id = imem[s.idx]; end
                  S_FIN:    begin e_done = 1; e_ic = 1; m_active = 0; end
                  default:  ;
               endcase
            end
         end
         e_busy = was_active && m_active;
         if (!was_active && wr_en) begin
            if (!wr_sel && wr_addr < NK)     kmem[wr_addr] = wr_data;
            else if (wr_sel && wr_addr < NI) imem[wr_addr] = wr_data;
         end
         if (!was_active && start) begin
            slots.delete();
            slots.push_back('{S_FETCH, 0});
            for (int i = 0; i < NK; i++) slots.push_back('{S_KW, i});
            slots.push_back('{S_SWITCH, 0});
            for (int r = 0; r < IMG_H; r++) begin
               for (int c = 0; c < IMG_W; c++) slots.push_back('{S_PIX, r * IMG_W + c});
               if (GAP_EN) slots.push_back('{S_GAP, 0});
            end
            slots.push_back('{S_FIN, 0});
            m_active  = 1;
            e_kc      = 0;
            e_ic      = 0;
            s_edge    = cyc;
            stall_cnt = 0;
         end
      end
   end

   int tests = 0, fails = 0;
   bit chk_en = 0;

   // Observed per-run metrics, pinned against hand-computed literals.
   int        first_kv, first_kd, kc_rel, first_iv, first_id, done_rel, done_cnt, beef_seen;
   bit        kc_prev = 0;
   bit [15:0] pix_seen[$];
   int        pix_rel[$];

   function automatic int rel_now();
      return cyc - s_edge;
   endfunction

   function automatic logic [37:0] dut_vec();
      return {busy, done, kernal_input_valid, kernal_input, kernal_complete,
              image_input_valid, image_input_pixel, image_complete};
   endfunction

   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         tests++;
         if (dut_vec() !== {e_busy, e_done, e_kv, e_kd, e_kc, e_iv, e_id, e_ic}) begin
            fails++;
            $display("FAIL cycle_cmp rel=%0d got busy/done/kv/kd/kc/iv/id/ic=%b%b%b %h %b%b %h %b expected %b%b%b %h %b%b %h %b",
                     rel_now(), busy, done, kernal_input_valid, kernal_input, kernal_complete,
                     image_input_valid, image_input_pixel, image_complete,
                     e_busy, e_done, e_kv, e_kd, e_kc, e_iv, e_id, e_ic);
         end
         if (kernal_input_valid && first_kv < 0) begin first_kv = rel_now(); first_kd = kernal_input; end
         if (kernal_input_valid && kernal_input == 16'hBEEF) beef_seen++;
         if (kernal_complete && !kc_prev && kc_rel < 0) kc_rel = rel_now();
         if (image_input_valid) begin
            if (first_iv < 0) begin first_iv = rel_now(); first_id = image_input_pixel; end
            pix_seen.push_back(image_input_pixel);
            pix_rel.push_back(rel_now());
         end
         if (done) begin done_rel = rel_now(); done_cnt++; end
      end
      kc_prev = kernal_complete;
   end

   task automatic check(input string name, input longint got, input longint exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic host_write(input bit sel, input int addr, input int data);
      wr_en = 1; wr_sel = sel; wr_addr = 10'(addr); wr_data = 16'(data);
      @(negedge clk);
      wr_en = 0;
   endtask

   task automatic run_start();
      first_kv = -1; first_kd = -1; kc_rel = -1; first_iv = -1; first_id = -1;
      done_rel = -1; done_cnt = 0; beef_seen = 0;
      pix_seen.delete();
      pix_rel.delete();
      start = 1;
      @(negedge clk);
      start = 0;
   endtask

   task automatic wait_rel(input int n);
      int k = 0;
      while (rel_now() < n && k < 5000) begin @(negedge clk); k++; end
      if (rel_now() < n) check("wait_rel_timeout", rel_now(), n);
   endtask

   task automatic wait_done(input string name);
      int k = 0;
      while (done_rel < 0 && k < 5000) begin @(negedge clk); #1; k++; end
      if (done_rel < 0) check({name, "_timeout"}, done_rel, DONE_REL);
      repeat (3) @(negedge clk);
   endtask

   function automatic int seq_errs();
      int e = 0;
      if (pix_seen.size() != NI) e++;
      foreach (pix_seen[i]) if (pix_seen[i] != 16'(i + 100)) e++;
      return e;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      check("reset_outputs", dut_vec(), 0);
      rst_n  = 1;
      chk_en = 1;

      // Load with stall held high: stall has no effect while idle.
      stall = 1;
      for (int i = 0; i < NK; i++) host_write(0, i, i + 1);
      for (int i = 0; i < NI; i++) host_write(1, i, i + 100);
      host_write(0, 25, 16'hBEEF);
      host_write(1, 900, 16'hBEEF);
      stall = 0;
      @(negedge clk);

      // Basic playback
      run_start();
      wait_done("basic");
      check("basic_first_kv_cycle", first_kv, 2);
      check("basic_first_kernel", first_kd, 1);
      check("basic_kc_cycle", kc_rel, 27);
      check("basic_first_pix_cycle", first_iv, 28);
      check("basic_first_pix", first_id, 100);
      check("basic_done_cycle", done_rel, DONE_REL);
      check("basic_pix_seq_errs", seq_errs(), 0);
      check("oor_kernel_beef_words", beef_seen, 0);

      // Stall three cycles just before pixel 40
      run_start();
      n = 0;
      while (pix_seen.size() < 40 && n < 2000) begin @(negedge clk); #1; n++; end
      check("stall_reached_pix40", pix_seen.size(), 40);
      stall = 1;
      repeat (3) @(negedge clk);
      stall = 0;
      wait_done("stall");
      check("stall_done_cycle", done_rel, DONE_REL + 3);
      check("stall_pix_seq_errs", seq_errs(), 0);
      if (pix_rel.size() > 40) check("stall_pix40_gap", pix_rel[40] - pix_rel[39], 4);
      else check("stall_pix40_missing", pix_rel.size(), 41);

      // Write and start while busy are ignored
      run_start();
      wait_rel(100);
      wr_en = 1; wr_sel = 1; wr_addr = '0; wr_data = 16'hFFFF; start = 1;
      @(negedge clk);
      wr_en = 0; start = 0;
      wait_done("busy_wr");
      check("busy_wr_done_cycle", done_rel, DONE_REL);
      check("busy_wr_pix_seq_errs", seq_errs(), 0);
      run_start();
      wait_done("replay");
      check("replay_first_pix", first_id, 100);

      // Reset mid-playback
      run_start();
      wait_rel(300);
      #2 rst_n = 0;
      #1 check("async_reset_outputs", dut_vec(), 0);
      repeat (2) @(negedge clk);
      rst_n = 1;
      repeat (4) @(negedge clk);
      check("abort_no_done", done_cnt, 0);
      run_start();
      wait_done("post_reset");
      check("post_reset_first_kernel", first_kd, 1);
      check("post_reset_first_pix", first_id, 100);
      check("post_reset_done_cycle", done_rel, DONE_REL);
      check("post_reset_pix_seq_errs", seq_errs(), 0);

      // Random contents, random stalls, random ignored writes/starts
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < NK; i++) host_write(0, i, int'($urandom_range(0, 65535)));
         for (int i = 0; i < NI; i++) host_write(1, i, int'($urandom_range(0, 65535)));
         run_start();
         n = 0;
         while (done_rel < 0 && n < 4000) begin
            stall   = ($urandom_range(0, 7) == 0);
            wr_en   = ($urandom_range(0, 15) == 0);
            wr_sel  = 1'($urandom_range(0, 1));
            wr_addr = 10'($urandom_range(0, 1023));
            wr_data = 16'($urandom);
            start   = ($urandom_range(0, 31) == 0);
            @(negedge clk); #1;
            n++;
         end
         stall = 0; wr_en = 0; start = 0;
         check("rand_done_cycle", done_rel, DONE_REL + stall_cnt);
         repeat (3) @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/conv_2d_feeder.md
# conv_2d_feeder

Stream source that drives the `conv_2d` input interface for LeNet inference. A host preloads one kernel and one image into two local buffers. On `start`, the block plays the kernel out word-by-word, then the image pixel-by-pixel in row-major order, and raises the `kernal_complete` and `image_complete` flags. It sits directly in front of `conv_2d` and replaces bench-driven stimulus in the integrated datapath.

## Interface

Parameters:
- `DATA_W`, 16: width of kernel words and pixels.
- `KSIZE`, 5: kernel edge; the kernel holds KSIZE*KSIZE words.
- `IMG_W`, 28: image width in pixels.
- `IMG_H`, 28: image height in pixels.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `wr_en`, in, 1: host buffer write strobe.
- `wr_sel`, in, 1: 0 = kernel buffer, 1 = image buffer.
- `wr_addr`, in, clog2(IMG_W*IMG_H): word address.
- `wr_data`, in, DATA_W: write data.
- `start`, in, 1: begin playback; single-cycle pulse.
- `stall`, in, 1: freeze the stream while high.
- `busy`, out, 1: playback in progress.
- `done`, out, 1: one-cycle pulse when playback ends.
- `kernal_input`, out, DATA_W: kernel word.
- `kernal_input_valid`, out, 1: `kernal_input` is valid.
- `kernal_complete`, out, 1: kernel fully sent (level).
- `image_input_pixel`, out, DATA_W: pixel.
- `image_input_valid`, out, 1: `image_input_pixel` is valid.
- `image_complete`, out, 1: image fully sent (level).

## Operation

- **Reset:** every output is 0 and the FSM enters IDLE. Buffer contents are not reset. Reset mid-playback aborts immediately and emits no `done`.
- **Host writes:**
  - Accepted only in IDLE.
  - Ignored while `busy`.
  - Ignored when `wr_addr` is out of range (≥ KSIZE*KSIZE for kernel, ≥ IMG_W*IMG_H for image).
- **FSM states:** IDLE → KFETCH → KSEND → ISWITCH → ISEND → FINISH → IDLE.
  - `start` is honoured only in IDLE; it is ignored otherwise.
  - Accepting `start` clears `kernal_complete` and `image_complete`.
  - KSEND issues KSIZE*KSIZE kernel words, index 0 first.
  - ISEND issues IMG_W*IMG_H pixels, row-major, index 0 first.
- **Data outputs:** `kernal_input` and `image_input_pixel` are forced to 0 whenever their valid is low. All outputs are registered.
- **Stall:**
  - While `stall` is high, both valids are low and the address counters and FSM hold.
  - The stream resumes with the next unsent word, and no word is dropped or repeated.
  - `stall` in IDLE has no effect.
- **Completion flags:** `kernal_complete` and `image_complete` are levels, held high until the next accepted `start`.
- **Counters:** the address counter saturates at its last index; it never wraps within a phase.

## Timing

Edge 0 is the edge that samples `start` high. With no stall:
- `busy` is high from cycle 1 until `done`.
- Kernel words are valid on cycles 2 .. K²+1. The sync-read buffer costs one cycle, plus one cycle of address setup.
- `kernal_complete` rises on cycle K²+2. One switch bubble follows, with both valids low.
- Pixels are valid on cycles K²+3 .. K²+2+W*H.
- On cycle K²+3+W*H, `image_complete` rises, `done` pulses and `busy` falls.
- Defaults: kernel on cycles 2..26, `kernal_complete` at 27, pixels on 28..811, `done` at 812.
- Each stalled cycle adds exactly one cycle to every later event.
- A `start` arriving on the same cycle as `done` is ignored; IDLE is entered on the following cycle.

## Configuration

- `FEEDER_ROW_GAP_EN`, defined: after the last pixel of each image row (including the final row), insert one cycle with `image_input_valid` low. The image phase becomes W*H+H cycles, so `done` moves to K²+3+W*H+IMG_H (840 at defaults).
- Undefined: pixels are back-to-back, with the timing given above.

## Structure

- **Package `conv_feeder_pkg`:** FSM state enum, `KWORDS = KSIZE*KSIZE`, `IWORDS = IMG_W*IMG_H`, and the address-width constants.
- **Sub-module `feeder_ram`:** simple dual-port buffer (write port, synchronous read port). It is instantiated twice, with depth KWORDS and depth IWORDS.

## Test plan

- **Basic playback:** load kernel 1..25 and image pixel n = n+100, then pulse `start`.
  - Kernel values 1..25 appear on cycles 2..26.
  - `kernal_complete` rises at 27.
  - Pixels 100..883 appear on cycles 28..811.
  - `done` pulses at 812.
- **Stall:** hold `stall` high for 3 cycles at pixel index 40.
  - `image_input_valid` is low for 3 cycles.
  - Index 40 follows, with no gap or duplicate.
  - `done` arrives at 815.
- **Writes and start while busy:** during playback, write image addr 0 = 0xFFFF and pulse `start` at cycle 100.
  - Both are ignored; the stream and `done` are unchanged.
  - A replay shows pixel 0 = 100.
- **Out-of-range write:** write kernel addr 25 = 0xBEEF.
  - No kernel word equals 0xBEEF.
  - The image buffer is unaltered.
- **Reset mid-operation:** assert `rst_n` low at cycle 300.
  - All outputs are 0 asynchronously, and no `done` is emitted.
  - A subsequent `start` replays the retained buffers correctly.
- **`FEEDER_ROW_GAP_EN` build:** one invalid cycle after every 28th pixel; `done` at 840.
